// File: rtl/pc_seq_ctrl_pkg.sv
// pc_seq_pkg: shared definitions for the fetch/decode/execute sequencer.
//   state_t   - sequencer state encoding (STEP_WAIT only reachable when the
//               single-step build option PC_SEQ_CTRL_STEP_EN is defined)
//   STATE_W   - width of the state register
//   OP_JMP, OP_JZ, OP_HLT - control-flow opcodes recognised in DECODE
package pc_seq_pkg;

    localparam int STATE_W = 3;

    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_JZ  = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [STATE_W-1:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        LOAD_IR   = 3'd2,
        DECODE    = 3'd3,
        EXEC      = 3'd4,
        BRANCH    = 3'd5,
        HALT      = 3'd6,
        STEP_WAIT = 3'd7
    } state_t;

endpackage

// File: rtl/pc_seq_ctrl_if.sv
// pc_seq_ctrl_if: handshake/control bundle between the sequencer and its
// surroundings (instruction memory, IR, PC, datapath).
//   slave  modport - seen by the sequencer (takes start/mem_ready/opcode/
//                    z_flag[/step], drives strobes and status)
//   master modport - seen by whatever drives the sequencer inputs
// The step signal exists only when PC_SEQ_CTRL_STEP_EN is defined.
interface pc_seq_ctrl_if
    import pc_seq_pkg::*;
#(
    parameter int OPW  = 4,
    parameter int CNTW = 16
);
    logic            start;
    logic            mem_ready;
    logic [OPW-1:0]  opcode;
    logic            z_flag;
`ifdef PC_SEQ_CTRL_STEP_EN
    logic            step;
`endif
    logic            mem_rd;
    logic            ir_load;
    logic            pc_inc;
    logic            pc_load;
    logic            exec_en;
    logic            busy;
    logic            halted;
    logic            fault;
    logic [CNTW-1:0] retired;

    modport slave (
        input  start, mem_ready, opcode, z_flag,
`ifdef PC_SEQ_CTRL_STEP_EN
        input  step,
`endif
        output mem_rd, ir_load, pc_inc, pc_load, exec_en,
        output busy, halted, fault, retired
    );

    modport master (
        output start, mem_ready, opcode, z_flag,
`ifdef PC_SEQ_CTRL_STEP_EN
        output step,
`endif
        input  mem_rd, ir_load, pc_inc, pc_load, exec_en,
        input  busy, halted, fault, retired
    );

endinterface

// File: rtl/pc_seq_ctrl_tmo.sv
// pc_seq_tmo: fetch timeout counter.
//   clk    - system clock
//   rst_n  - synchronous active-low reset
//   clr    - zero the count (memory answered, or not fetching)
//   en     - count this cycle (fetching, no mem_ready yet)
//   expire - the current waiting cycle is the TMO-th one
module pc_seq_tmo
    import pc_seq_pkg::*;
#(
    parameter int TMO = 15,
    parameter int TW  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [TW-1:0] LAST = TW'(TMO - 1);

    logic [TW-1:0] cnt_q;

    // Counts consecutive unanswered fetch cycles; first wait cycle sees 0.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire = en && (cnt_q == LAST);

endmodule

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: fetch/decode/execute sequencer driving PC, IR and memory
// read strobes; counts retired instructions and halts on a memory timeout.
//   clk   - system clock
//   rst_n - synchronous active-low reset
//   bus   - pc_seq_ctrl_if.slave: start, mem_ready, opcode, z_flag
//           [, step] in; mem_rd, ir_load, pc_inc, pc_load, exec_en,
//           busy, halted, fault, retired out
// Build option PC_SEQ_CTRL_STEP_EN: adds the step input and parks in
// STEP_WAIT after every retired instruction until step is seen high.
module pc_seq_ctrl
    import pc_seq_pkg::*;
#(
    parameter int OPW  = 4,
    parameter int TMO  = 15,
    parameter int TW   = 4,
    parameter int CNTW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_seq_ctrl_if.slave  bus
);

`ifdef PC_SEQ_CTRL_STEP_EN
    localparam state_t RET_NEXT = STEP_WAIT;
`else
    localparam state_t RET_NEXT = FETCH;
`endif

    state_t          state_q, state_d;
    logic            fault_q;
    logic [CNTW-1:0] retired_q;
    logic            retire;
    logic            tmo_clr, tmo_en, tmo_expire;

    // The timeout only runs while waiting on memory in FETCH.
    assign tmo_en  = (state_q == FETCH) && !bus.mem_ready;
    assign tmo_clr = (state_q != FETCH) || bus.mem_ready;

    pc_seq_tmo #(
        .TMO (TMO),
        .TW  (TW)
    ) u_tmo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmo_clr),
        .en     (tmo_en),
        .expire (tmo_expire)
    );

    // Next-state decode; retire marks the cycle an instruction completes
    // (EXEC, BRANCH, or an untaken JZ resolved directly in DECODE).
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            IDLE:    if (bus.start) state_d = FETCH;
            FETCH: begin
                if (bus.mem_ready)   state_d = LOAD_IR;
                else if (tmo_expire) state_d = HALT;
            end
            LOAD_IR: state_d = DECODE;
            DECODE: begin
                if (bus.opcode == OP_HLT) begin
                    state_d = HALT;
                end else if (bus.opcode == OP_JMP) begin
                    state_d = BRANCH;
                end else if (bus.opcode == OP_JZ && bus.z_flag) begin
                    state_d = BRANCH;
                end else if (bus.opcode == OP_JZ) begin
                    state_d = RET_NEXT;
                    retire  = 1'b1;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC, BRANCH: begin
                state_d = RET_NEXT;
                retire  = 1'b1;
            end
            HALT:    state_d = HALT;
`ifdef PC_SEQ_CTRL_STEP_EN
            STEP_WAIT: if (bus.step) state_d = FETCH;
`else
            STEP_WAIT: state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // State, sticky fault and retired count share one reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            fault_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            fault_q   <= fault_q | tmo_expire;
            retired_q <= retired_q + CNTW'(retire);
        end
    end

    // Moore outputs straight off the state register.
    assign bus.mem_rd  = (state_q == FETCH);
    assign bus.ir_load = (state_q == LOAD_IR);
    assign bus.pc_inc  = (state_q == LOAD_IR);
    assign bus.exec_en = (state_q == EXEC);
    assign bus.pc_load = (state_q == BRANCH);
    assign bus.halted  = (state_q == HALT);
    assign bus.busy    = (state_q != IDLE) && (state_q != HALT);
    assign bus.fault   = fault_q;
    assign bus.retired = retired_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl: directed self-checking bench for pc_seq_ctrl.
// Scenarios: reset, plain execute, JMP, JZ taken/untaken, strobe
// exclusivity, HLT with mid-HALT reset, fetch timeout, and (with
// PC_SEQ_CTRL_STEP_EN) single stepping.
module tb_pc_seq_ctrl;
    import pc_seq_pkg::*;

    logic clk;
    logic rst_n;
    int   testsRun;
    int   testsFailed;
    int   pcIncCount, pcLoadCount, execCount, irLoadCount, exclViol;

    pc_seq_ctrl_if #(.OPW(4), .CNTW(16)) bus ();

    pc_seq_ctrl #(.OPW(4), .TMO(15), .TW(4), .CNTW(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters and strobe-exclusivity watcher, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.pc_inc === 1'b1)  pcIncCount++;
        if (bus.pc_load === 1'b1) pcLoadCount++;
        if (bus.exec_en === 1'b1) execCount++;
        if (bus.ir_load === 1'b1) irLoadCount++;
        if (bus.pc_inc === 1'b1 && bus.pc_load === 1'b1) exclViol++;
        if (({1'b0, bus.ir_load} + {1'b0, bus.exec_en} + {1'b0, bus.pc_load}) > 2'd1) exclViol++;
    end

    // Set inputs, then advance one clock and settle 1 ns past the edge.
    task automatic applyStimulus(input logic st, input logic rdy, input logic [3:0] op, input logic z);
        bus.start     = st;
        bus.mem_ready = rdy;
        bus.opcode    = op;
        bus.z_flag    = z;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
        rst_n = 1'b1;
        testsRun++; if (bus.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
        testsRun++; if (bus.halted !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_halted got %b want 0", bus.halted); end
        testsRun++; if (bus.fault !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_fault got %b want 0", bus.fault); end
        testsRun++; if (bus.retired !== 16'd0) begin testsFailed++; $display("[TB] FAIL reset_retired got %0d want 0", bus.retired); end
        testsRun++;
        if ({bus.mem_rd, bus.ir_load, bus.pc_inc, bus.pc_load, bus.exec_en} !== 5'b0) begin
            testsFailed++; $display("[TB] FAIL reset_strobes got %b want 00000", {bus.mem_rd, bus.ir_load, bus.pc_inc, bus.pc_load, bus.exec_en});
        end
        applyStimulus(1'b0, 1'b1, 4'h0, 1'b0);
        testsRun++; if (bus.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL idle_no_start got busy %b want 0", bus.busy); end
    endtask

    // Ends observing the first FETCH cycle of the next instruction.
    task automatic test_exec();
        int inc0, ex0;
        inc0 = pcIncCount; ex0 = execCount;
        applyStimulus(1'b1, 1'b0, 4'h1, 1'b0);
        testsRun++; if (bus.mem_rd !== 1'b1) begin testsFailed++; $display("[TB] FAIL exec_fetch1 mem_rd got %b want 1", bus.mem_rd); end
        applyStimulus(1'b0, 1'b0, 4'h1, 1'b0);
        testsRun++; if (bus.mem_rd !== 1'b1) begin testsFailed++; $display("[TB] FAIL exec_fetch2 mem_rd got %b want 1", bus.mem_rd); end
        applyStimulus(1'b0, 1'b1, 4'h1, 1'b0);
        testsRun++; if ({bus.ir_load, bus.pc_inc} !== 2'b11) begin testsFailed++; $display("[TB] FAIL exec_load_ir got %b want 11", {bus.ir_load, bus.pc_inc}); end
        applyStimulus(1'b0, 1'b0, 4'h1, 1'b0);
        testsRun++;
        if ({bus.busy, bus.mem_rd, bus.ir_load, bus.exec_en, bus.pc_load} !== 5'b10000) begin
            testsFailed++; $display("[TB] FAIL exec_decode got %b want 10000", {bus.busy, bus.mem_rd, bus.ir_load, bus.exec_en, bus.pc_load});
        end
        applyStimulus(1'b0, 1'b0, 4'h1, 1'b0);
        testsRun++; if (bus.exec_en !== 1'b1) begin testsFailed++; $display("[TB] FAIL exec_exec got %b want 1", bus.exec_en); end
        applyStimulus(1'b0, 1'b0, 4'h1, 1'b0);
        testsRun++; if (bus.mem_rd !== 1'b1) begin testsFailed++; $display("[TB] FAIL exec_refetch got %b want 1", bus.mem_rd); end
        testsRun++; if (bus.retired !== 16'd1) begin testsFailed++; $display("[TB] FAIL exec_retired got %0d want 1", bus.retired); end
        testsRun++; if (pcIncCount - inc0 !== 1) begin testsFailed++; $display("[TB] FAIL exec_pc_inc_pulses got %0d want 1", pcIncCount - inc0); end
        testsRun++; if (execCount - ex0 !== 1) begin testsFailed++; $display("[TB] FAIL exec_en_pulses got %0d want 1", execCount - ex0); end
    endtask

    task automatic test_jmp();
        int ld0;
        ld0 = pcLoadCount;
        applyStimulus(1'b0, 1'b1, OP_JMP, 1'b0);
        applyStimulus(1'b0, 1'b0, OP_JMP, 1'b0);
        testsRun++; if (bus.pc_load !== 1'b0) begin testsFailed++; $display("[TB] FAIL jmp_decode_pc_load got %b want 0", bus.pc_load); end
        applyStimulus(1'b0, 1'b0, OP_JMP, 1'b0);
        testsRun++; if ({bus.pc_load, bus.pc_inc} !== 2'b10) begin testsFailed++; $display("[TB] FAIL jmp_branch got %b want 10", {bus.pc_load, bus.pc_inc}); end
        applyStimulus(1'b0, 1'b0, OP_JMP, 1'b0);
        testsRun++; if (bus.mem_rd !== 1'b1) begin testsFailed++; $display("[TB] FAIL jmp_refetch got %b want 1", bus.mem_rd); end
        testsRun++; if (bus.retired !== 16'd2) begin testsFailed++; $display("[TB] FAIL jmp_retired got %0d want 2", bus.retired); end
        testsRun++; if (pcLoadCount - ld0 !== 1) begin testsFailed++; $display("[TB] FAIL jmp_pc_load_pulses got %0d want 1", pcLoadCount - ld0); end
    endtask

    task automatic test_jz();
        int ld0;
        ld0 = pcLoadCount;
        applyStimulus(1'b0, 1'b1, OP_JZ, 1'b0);
        applyStimulus(1'b0, 1'b0, OP_JZ, 1'b0);
        applyStimulus(1'b0, 1'b0, OP_JZ, 1'b0);
        testsRun++; if ({bus.mem_rd, bus.pc_load} !== 2'b10) begin testsFailed++; $display("[TB] FAIL jz_untaken got %b want 10", {bus.mem_rd, bus.pc_load}); end
        testsRun++; if (bus.retired !== 16'd3) begin testsFailed++; $display("[TB] FAIL jz_untaken_retired got %0d want 3", bus.retired); end
        applyStimulus(1'b0, 1'b1, OP_JZ, 1'b1);
        applyStimulus(1'b0, 1'b0, OP_JZ, 1'b1);
        applyStimulus(1'b0, 1'b0, OP_JZ, 1'b1);
        testsRun++; if (bus.pc_load !== 1'b1) begin testsFailed++; $display("[TB] FAIL jz_taken got %b want 1", bus.pc_load); end
        applyStimulus(1'b0, 1'b0, OP_JZ, 1'b0);
        testsRun++; if (bus.retired !== 16'd4) begin testsFailed++; $display("[TB] FAIL jz_taken_retired got %0d want 4", bus.retired); end
        testsRun++; if (pcLoadCount - ld0 !== 1) begin testsFailed++; $display("[TB] FAIL jz_pc_load_pulses got %0d want 1", pcLoadCount - ld0); end
    endtask

    task automatic test_exclusive();
        testsRun++; if (exclViol !== 0) begin testsFailed++; $display("[TB] FAIL strobe_exclusive got %0d violations want 0", exclViol); end
    endtask

    task automatic test_hlt();
        applyStimulus(1'b0, 1'b1, OP_HLT, 1'b0);
        applyStimulus(1'b0, 1'b0, OP_HLT, 1'b0);
        applyStimulus(1'b0, 1'b0, OP_HLT, 1'b0);
        testsRun++; if ({bus.halted, bus.busy} !== 2'b10) begin testsFailed++; $display("[TB] FAIL hlt_state got %b want 10", {bus.halted, bus.busy}); end
        testsRun++; if (bus.retired !== 16'd4) begin testsFailed++; $display("[TB] FAIL hlt_retired got %0d want 4", bus.retired); end
        applyStimulus(1'b1, 1'b1, 4'h1, 1'b0);
        testsRun++; if (bus.halted !== 1'b1) begin testsFailed++; $display("[TB] FAIL hlt_sticky got %b want 1", bus.halted); end
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
        rst_n = 1'b1;
        testsRun++; if ({bus.halted, bus.busy} !== 2'b00) begin testsFailed++; $display("[TB] FAIL hlt_reset_state got %b want 00", {bus.halted, bus.busy}); end
        testsRun++; if (bus.retired !== 16'd0) begin testsFailed++; $display("[TB] FAIL hlt_reset_retired got %0d want 0", bus.retired); end
    endtask

    task automatic test_timeout();
        int fetchCycles;
        applyStimulus(1'b1, 1'b0, 4'h1, 1'b0);
        fetchCycles = 0;
        for (int i = 0; i < 40 && bus.halted !== 1'b1; i++) begin
            if (bus.mem_rd === 1'b1) fetchCycles++;
            applyStimulus(1'b0, 1'b0, 4'h1, 1'b0);
        end
        testsRun++; if (fetchCycles !== 15) begin testsFailed++; $display("[TB] FAIL tmo_fetch_cycles got %0d want 15", fetchCycles); end
        testsRun++;
        if ({bus.halted, bus.fault, bus.busy, bus.mem_rd} !== 4'b1100) begin
            testsFailed++; $display("[TB] FAIL tmo_status got %b want 1100", {bus.halted, bus.fault, bus.busy, bus.mem_rd});
        end
        applyStimulus(1'b1, 1'b1, 4'h1, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'h1, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'h1, 1'b0);
        testsRun++; if ({bus.halted, bus.fault} !== 2'b11) begin testsFailed++; $display("[TB] FAIL tmo_start_ignored got %b want 11", {bus.halted, bus.fault}); end
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
        rst_n = 1'b1;
        testsRun++; if ({bus.halted, bus.fault} !== 2'b00) begin testsFailed++; $display("[TB] FAIL tmo_reset_clears got %b want 00", {bus.halted, bus.fault}); end
    endtask

`ifdef PC_SEQ_CTRL_STEP_EN
    task automatic test_step();
        int ir0;
        bus.step = 1'b0;
        applyStimulus(1'b1, 1'b1, 4'h1, 1'b0);
        ir0 = irLoadCount;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 4'h1, 1'b0);
            applyStimulus(1'b0, 1'b1, 4'h1, 1'b0);
            applyStimulus(1'b0, 1'b1, 4'h1, 1'b0);
            applyStimulus(1'b0, 1'b1, 4'h1, 1'b0);
            for (int w = 0; w < 3; w++) begin
                testsRun++;
                if ({bus.busy, bus.mem_rd, bus.exec_en} !== 3'b100) begin
                    testsFailed++; $display("[TB] FAIL step_parked[%0d] got %b want 100", k, {bus.busy, bus.mem_rd, bus.exec_en});
                end
                applyStimulus(1'b0, 1'b1, 4'h1, 1'b0);
            end
            bus.step = 1'b1;
            applyStimulus(1'b0, 1'b1, 4'h1, 1'b0);
            bus.step = 1'b0;
            testsRun++; if (bus.mem_rd !== 1'b1) begin testsFailed++; $display("[TB] FAIL step_fetch[%0d] got %b want 1", k, bus.mem_rd); end
        end
        testsRun++; if (bus.retired !== 16'd3) begin testsFailed++; $display("[TB] FAIL step_retired got %0d want 3", bus.retired); end
        testsRun++; if (irLoadCount - ir0 !== 3) begin testsFailed++; $display("[TB] FAIL step_fetch_count got %0d want 3", irLoadCount - ir0); end
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        testsRun = 0; testsFailed = 0;
        pcIncCount = 0; pcLoadCount = 0; execCount = 0; irLoadCount = 0; exclViol = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.mem_ready = 1'b0; bus.opcode = 4'h0; bus.z_flag = 1'b0;
`ifdef PC_SEQ_CTRL_STEP_EN
        bus.step = 1'b0;
        test_reset();
        test_step();
`else
        test_reset();
        test_exec();
        test_jmp();
        test_jz();
        test_exclusive();
        test_hlt();
        test_timeout();
`endif
        test_exclusive();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
- Fetch/decode/execute sequencer that drives the program counter's load and increment strobes, plus instruction-register and memory-read control.
- Sits between instruction memory, the instruction register and the PC, and decides per instruction whether the PC increments or loads from C_bus.
- Also counts retired instructions and halts on a memory-ready timeout.

Parameters:
- OPW, 4, opcode width
- TMO, 15, max mem_ready wait cycles before fault (1..2^TW-1)
- TW, 4, timeout counter width
- CNTW, 16, retired-instruction counter width
- OP_JMP, 4'hA, unconditional jump opcode
- OP_JZ, 4'hB, jump-if-zero opcode
- OP_HLT, 4'hF, halt opcode

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk
- start  in  1  level; leave IDLE when high
- mem_ready  in  1  instruction memory data valid
- opcode  in  OPW  IR opcode field, valid from DECODE onward
- z_flag  in  1  ALU zero flag, sampled in DECODE
- mem_rd  out  1  instruction read request
- ir_load  out  1  load instruction register
- pc_inc  out  1  PC increment strobe
- pc_load  out  1  PC load-from-C_bus strobe
- exec_en  out  1  one-cycle datapath execute enable
- busy  out  1  high in any state except IDLE/HALT
- halted  out  1  high in HALT
- fault  out  1  sticky; memory timeout occurred
- retired  out  CNTW  retired-instruction count

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, tmo_cnt=0, retired=0, fault=0. All strobes 0, busy=0, halted=0.
- Reset has priority in every state, including mid-FETCH and HALT.
- Outputs are Moore-decoded from the state register; no output is registered separately except fault and retired.
- States and transitions:
  - IDLE: start=1 -> FETCH.
  - FETCH: mem_rd=1.
    - mem_ready=1 -> LOAD_IR, tmo_cnt<=0.
    - Else tmo_cnt++; tmo_cnt==TMO-1 with no ready -> HALT, fault<=1.
  - LOAD_IR: ir_load=1, pc_inc=1 (PC advances exactly once per fetch). -> DECODE.
  - DECODE, first matching rule:
    - opcode==OP_HLT -> HALT
    - opcode==OP_JMP -> BRANCH
    - opcode==OP_JZ and z_flag=1 -> BRANCH
    - opcode==OP_JZ and z_flag=0 -> FETCH, retired++
    - otherwise -> EXEC
  - EXEC: exec_en=1 for one cycle, retired++ -> FETCH.
  - BRANCH: pc_load=1, retired++ -> FETCH.
  - HALT: halted=1; exits only via rst_n. HLT itself is not counted as retired.
- Strobe exclusivity: pc_inc and pc_load are never high in the same cycle. At most one of ir_load/exec_en/pc_load is high per cycle.
- Latency:
  - Non-branch instruction: fetch wait + 3 cycles (LOAD_IR, DECODE, EXEC).
  - Branch: fetch wait + 3 cycles (LOAD_IR, DECODE, BRANCH).
  - Untaken JZ: fetch wait + 2 cycles.
- retired wraps modulo 2^CNTW; no saturation.
- start is ignored outside IDLE. Deasserting start mid-program has no effect.
- mem_ready outside FETCH is ignored.

Optional Feature:
- Macro: PC_SEQ_CTRL_STEP_EN
- Defined: adds input port step (1 bit) and state STEP_WAIT.
  - After each EXEC/BRANCH/untaken-JZ the FSM enters STEP_WAIT instead of FETCH.
  - It leaves STEP_WAIT to FETCH on the cycle step=1; step is level-sampled.
  - busy=1 in STEP_WAIT.
- Undefined: no step port, no STEP_WAIT; free-running as above.

Decomposition:
- Package pc_seq_pkg holds:
  - state enum (IDLE, FETCH, LOAD_IR, DECODE, EXEC, BRANCH, HALT, STEP_WAIT)
  - opcode localparams OP_JMP/OP_JZ/OP_HLT
  - state encoding width
- One sub-module is natural: pc_seq_tmo, the fetch timeout counter.
  - Inputs: clk, rst_n, clr, en.
  - Output: expire, high when the count reaches TMO-1 with en high.

Test Plan:
- Reset then start=1; mem_ready returns 1 in the 2nd FETCH cycle; opcode=4'h1 -> pc_inc exactly once, exec_en once, retired=1. Cycle sequence: FETCH, FETCH, LOAD_IR, DECODE, EXEC.
- opcode=OP_JMP -> pc_load=1 exactly one cycle after DECODE; pc_inc and pc_load never coincide; retired increments by 1.
- opcode=OP_JZ: z_flag=0 -> no pc_load, back to FETCH; repeat with z_flag=1 -> pc_load pulse. Counts after both: retired=2, pc_load pulses=1.
- mem_ready held 0 with TMO=15 -> after exactly 15 FETCH cycles: halted=1, fault=1, busy=0; further start ignored.
- opcode=OP_HLT -> halted=1, retired unchanged. Then rst_n=0 for one cycle mid-HALT -> IDLE, fault=0, retired=0.
- With PC_SEQ_CTRL_STEP_EN defined, 3 instructions -> FSM parks in STEP_WAIT after each. Exactly one fetch follows each step pulse; retired=3 after 3 steps.
